// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the NPC next-PC generator:
//   - state_t   : fetch FSM state encoding (BOOT, RUN, FROZEN, HALT)
//   - src_t     : identifies which source supplies the next PC
//   - F3_*      : RV conditional-branch funct3 encodings
//   - RESET_PC_DEFAULT : default reset fetch address
//   - target_misaligned() : alignment check on the two target LSBs
// -----------------------------------------------------------------------------
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      SRC_HOLD     = 3'd0,
      SRC_SEQ      = 3'd1,
      SRC_EX       = 3'd2,
      SRC_MRET     = 3'd3,
      SRC_TRAP     = 3'd4,
      SRC_MISALIGN = 3'd5
   } src_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   // JALR already has bit0 cleared, so only bit1 matters for it; branch and
   // JAL targets are misaligned if either of the two LSBs is set.
   function automatic logic target_misaligned(input logic [1:0] lsbs,
                                              input logic       is_jalr);
      logic bad;
      if (is_jalr) begin
         bad = lsbs[1];
      end else begin
         bad = lsbs[1] | lsbs[0];
      end
      return bad;
   endfunction

endpackage : pc_gen_pkg

// File: rtl/pc_gen_br_cond.sv
// -----------------------------------------------------------------------------
// br_cond
// Combinational RV conditional-branch resolver. Kept standalone so a future
// branch predictor can reuse the same comparator.
// Ports:
//   funct3 in  3     branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1    in  XLEN  first operand
//   rs2    in  XLEN  second operand
//   taken  out 1     branch condition holds; 0 for reserved funct3 010/011
// -----------------------------------------------------------------------------
module br_cond
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken
);

   logic eq_s;
   logic lt_s;
   logic ltu_s;

   assign eq_s  = (rs1 == rs2);
   assign lt_s  = ($signed(rs1) < $signed(rs2));
   assign ltu_s = (rs1 < rs2);

   // Select the comparison matching the branch type.
   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = eq_s;
         F3_BNE:  taken = ~eq_s;
         F3_BLT:  taken = lt_s;
         F3_BGE:  taken = ~lt_s;
         F3_BLTU: taken = ltu_s;
         F3_BGEU: taken = ~ltu_s;
         default: taken = 1'b0;
      endcase
   end

endmodule : br_cond

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Registered next-PC generator and fetch-address source for the NPC core.
// Owns the fetch PC, offers it to the IFU with a valid/ready handshake and
// arbitrates trap entry, mret return and EX-stage control-flow redirects.
//
// Optional feature macro: PC_GEN_MISALIGN_EN
//   defined   : misaligned EX targets are not taken; misalign pulses and the
//               pc is held while the front end is flushed.
//   undefined : misalign / misalign_addr tied to 0, targets used unmodified.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               global run enable (0 freezes pc and state)
//   halt              ebreak retire, enters HALT until reset
//   pc, pc_valid      fetch address offered to IFU
//   if_ready          IFU accepts pc this cycle
//   ex_*              resolved control-flow instruction from EX
//   trap_valid/vec    trap entry and its target
//   mret_valid/mepc   mret return and its target
//   flush             combinational; kill younger IF/ID instructions
//   misalign(_addr)   misaligned EX target report
//   redirect_cnt      saturating count of flushes
// -----------------------------------------------------------------------------
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN       = 64,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
   parameter int              ILEN_BYTES = 4,
   parameter int              CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             halt,
   output logic [XLEN-1:0]  pc,
   output logic             pc_valid,
   input  logic             if_ready,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic             ex_jalr,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic [XLEN-1:0]  ex_rs2,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             mret_valid,
   input  logic [XLEN-1:0]  mepc,
   output logic             flush,
   output logic             misalign,
   output logic [XLEN-1:0]  misalign_addr,
   output logic [CNT_W-1:0] redirect_cnt
);

   state_t            state_r;
   logic [XLEN-1:0]   pc_r;
   logic              pc_valid_r;
   logic [CNT_W-1:0]  cnt_r;

   logic              taken_s;
   logic              is_jalr_s;
   logic [XLEN-1:0]   br_target_s;
   logic [XLEN-1:0]   jalr_sum_s;
   logic [XLEN-1:0]   ex_target_s;
   logic              ex_take_s;
   logic              ex_bad_s;
   logic              active_s;
   src_t              src_s;
   logic [XLEN-1:0]   next_pc_s;
   logic              flush_s;

   br_cond #(
      .XLEN (XLEN)
   ) u_br_cond (
      .funct3 (ex_funct3),
      .rs1    (ex_rs1),
      .rs2    (ex_rs2),
      .taken  (taken_s)
   );

   // Target computation; all adds wrap modulo 2^XLEN.
   assign is_jalr_s   = ex_jump & ex_jalr;
   assign br_target_s = ex_pc + ex_imm;
   assign jalr_sum_s  = ex_rs1 + ex_imm;
   assign ex_target_s = is_jalr_s ? {jalr_sum_s[XLEN-1:1], 1'b0} : br_target_s;
   assign ex_take_s   = ex_valid & (ex_jump | (ex_branch & taken_s));

`ifdef PC_GEN_MISALIGN_EN
   assign ex_bad_s = target_misaligned(ex_target_s[1:0], is_jalr_s);
`else
   assign ex_bad_s = 1'b0;
`endif

   // Redirects and sequential advance are only considered while running or
   // frozen with ena high; a concurrent halt takes precedence over all of them.
   assign active_s = ena & ~halt &
                     ((state_r == ST_RUN) | (state_r == ST_FROZEN));

   // Next-PC arbitration: trap > mret > EX redirect > sequential > hold.
   // Redirects ignore the handshake; an unaccepted pc is simply discarded.
   always_comb begin
      src_s     = SRC_HOLD;
      next_pc_s = pc_r;
      if (!active_s) begin
         src_s     = SRC_HOLD;
         next_pc_s = pc_r;
      end else if (trap_valid) begin
         src_s     = SRC_TRAP;
         next_pc_s = trap_vec;
      end else if (mret_valid) begin
         src_s     = SRC_MRET;
         next_pc_s = mepc;
      end else if (ex_take_s && ex_bad_s) begin
         src_s     = SRC_MISALIGN;
         next_pc_s = pc_r;
      end else if (ex_take_s) begin
         src_s     = SRC_EX;
         next_pc_s = ex_target_s;
      end else if (pc_valid_r && if_ready) begin
         src_s     = SRC_SEQ;
         next_pc_s = pc_r + XLEN'(ILEN_BYTES);
      end else begin
         src_s     = SRC_HOLD;
         next_pc_s = pc_r;
      end
   end

   assign flush_s = (src_s == SRC_TRAP) | (src_s == SRC_MRET) |
                    (src_s == SRC_EX)   | (src_s == SRC_MISALIGN);

   // Fetch FSM with registered pc_valid; halt wins from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_BOOT;
         pc_valid_r <= 1'b0;
      end else if (halt) begin
         state_r    <= ST_HALT;
         pc_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               if (ena) begin
                  state_r    <= ST_RUN;
                  pc_valid_r <= 1'b1;
               end else begin
                  state_r    <= ST_BOOT;
                  pc_valid_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (ena) begin
                  state_r    <= ST_RUN;
                  pc_valid_r <= 1'b1;
               end else begin
                  state_r    <= ST_FROZEN;
                  pc_valid_r <= 1'b0;
               end
            end
            ST_FROZEN: begin
               if (ena) begin
                  state_r    <= ST_RUN;
                  pc_valid_r <= 1'b1;
               end else begin
                  state_r    <= ST_FROZEN;
                  pc_valid_r <= 1'b0;
               end
            end
            ST_HALT: begin
               state_r    <= ST_HALT;
               pc_valid_r <= 1'b0;
            end
            default: begin
               state_r    <= ST_BOOT;
               pc_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Architectural fetch PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= next_pc_s;
      end
   end

   // Saturating redirect counter, one increment per flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (flush_s && !(&cnt_r)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

`ifdef PC_GEN_MISALIGN_EN
   logic            misalign_r;
   logic [XLEN-1:0] misalign_addr_r;

   // One-cycle misalign pulse; the offending address is held until replaced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_r      <= 1'b0;
         misalign_addr_r <= {XLEN{1'b0}};
      end else if (src_s == SRC_MISALIGN) begin
         misalign_r      <= 1'b1;
         misalign_addr_r <= ex_target_s;
      end else begin
         misalign_r      <= 1'b0;
         misalign_addr_r <= misalign_addr_r;
      end
   end

   assign misalign      = misalign_r;
   assign misalign_addr = misalign_addr_r;
`else
   assign misalign      = 1'b0;
   assign misalign_addr = {XLEN{1'b0}};
`endif

   assign pc           = pc_r;
   assign pc_valid     = pc_valid_r;
   assign flush        = flush_s;
   assign redirect_cnt = cnt_r;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   localparam int          XLEN  = 64;
   localparam int          CNT_W = 4;
   localparam logic [63:0] RST   = 64'h0000_0000_8000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic             clk;
   logic             rst_n;
   logic             ena;
   logic             halt;
   logic [XLEN-1:0]  pc;
   logic             pc_valid;
   logic             if_ready;
   logic             ex_valid;
   logic             ex_branch;
   logic             ex_jump;
   logic             ex_jalr;
   logic [2:0]       ex_funct3;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic             trap_valid;
   logic [XLEN-1:0]  trap_vec;
   logic             mret_valid;
   logic [XLEN-1:0]  mepc;
   logic             flush;
   logic             misalign;
   logic [XLEN-1:0]  misalign_addr;
   logic [CNT_W-1:0] redirect_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] pc;
      logic        vld;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   pc_gen #(
      .XLEN       (XLEN),
      .RESET_PC   (RST),
      .ILEN_BYTES (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .halt          (halt),
      .pc            (pc),
      .pc_valid      (pc_valid),
      .if_ready      (if_ready),
      .ex_valid      (ex_valid),
      .ex_branch     (ex_branch),
      .ex_jump       (ex_jump),
      .ex_jalr       (ex_jalr),
      .ex_funct3     (ex_funct3),
      .ex_pc         (ex_pc),
      .ex_imm        (ex_imm),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .trap_valid    (trap_valid),
      .trap_vec      (trap_vec),
      .mret_valid    (mret_valid),
      .mepc          (mepc),
      .flush         (flush),
      .misalign      (misalign),
      .misalign_addr (misalign_addr),
      .redirect_cnt  (redirect_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redirects();
      ex_valid   = 1'b0;
      ex_branch  = 1'b0;
      ex_jump    = 1'b0;
      ex_jalr    = 1'b0;
      ex_funct3  = 3'b000;
      ex_pc      = 64'h0;
      ex_imm     = 64'h0;
      ex_rs1     = 64'h0;
      ex_rs2     = 64'h0;
      trap_valid = 1'b0;
      trap_vec   = 64'h0;
      mret_valid = 1'b0;
      mepc       = 64'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; ena = 1'b0; halt = 1'b0; if_ready = 1'b0;
      clear_redirects();
      #1 rst_n = 1'b0;
      #4;
      checks++;
      if (pc !== RST || pc_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=0", pc, pc_valid, RST);
      end
      checks++;
      if (redirect_cnt !== 4'd0 || flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt: cnt=%0d flush=%b, expected cnt=0 flush=0", redirect_cnt, flush);
      end
      checks++;
      if (misalign !== 1'b0 || misalign_addr !== 64'h0) begin
         errors++;
         $display("FAIL reset_misalign: misalign=%b addr=%h, expected 0/0", misalign, misalign_addr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      ena = 1'b1; if_ready = 1'b1;
      #1;
      checks++;
      if (pc_valid !== 1'b0 || pc !== RST) begin
         errors++;
         $display("FAIL boot: pc=%h pc_valid=%b, expected pc=%h pc_valid=0", pc, pc_valid, RST);
      end
      sb.push_back('{pc: 64'h8000_0000, vld: 1'b1});
      sb.push_back('{pc: 64'h8000_0004, vld: 1'b1});
      sb.push_back('{pc: 64'h8000_0008, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL seq: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
   endtask

   task automatic test_bne();
      ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = 3'b001;
      ex_rs1 = 64'd5; ex_rs2 = 64'd6;
      ex_pc = 64'h8000_0010; ex_imm = 64'hFFFF_FFFF_FFFF_FFF8;
      #1;
      checks++;
      if (flush !== 1'b1) begin
         errors++;
         $display("FAIL bne_flush: flush=%b, expected 1", flush);
      end
      sb.push_back('{pc: 64'h8000_0008, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL bne_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      checks++;
      if (redirect_cnt !== 4'd1) begin
         errors++;
         $display("FAIL bne_cnt: cnt=%0d, expected 1", redirect_cnt);
      end
      clear_redirects();
   endtask

   task automatic test_branch_conditions();
      logic [2:0]  f3 [13] = '{3'b110, 3'b100, 3'b000, 3'b000, 3'b001, 3'b101, 3'b101,
                               3'b111, 3'b111, 3'b010, 3'b011, 3'b100, 3'b110};
      logic [63:0] a  [13] = '{ONES, ONES, 64'd7, 64'd7, 64'd7, ONES, 64'd1,
                               ONES, 64'd1, 64'd7, 64'd7, 64'd1, 64'd1};
      logic [63:0] b  [13] = '{64'd1, 64'd1, 64'd7, 64'd8, 64'd7, 64'd1, ONES,
                               64'd1, ONES, 64'd8, 64'd7, ONES, ONES};
      logic        tk [13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      if_ready = 1'b0;
      ex_valid = 1'b1; ex_branch = 1'b1;
      ex_pc = 64'h8000_0100; ex_imm = 64'h20;
      // bltu with -1 vs 1 is not taken: pc holds
      ex_funct3 = 3'b110; ex_rs1 = ONES; ex_rs2 = 64'd1;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL bltu_flush: flush=%b, expected 0", flush);
      end
      sb.push_back('{pc: 64'h8000_0008, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL bltu_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      for (int i = 0; i < 13; i++) begin
         ex_funct3 = f3[i]; ex_rs1 = a[i]; ex_rs2 = b[i];
         #1;
         checks++;
         if (flush !== tk[i]) begin
            errors++;
            $display("FAIL cond_%0d: funct3=%b flush=%b, expected %b", i, f3[i], flush, tk[i]);
         end
      end
      // blt with -1 vs 1 is taken
      ex_funct3 = 3'b100; ex_rs1 = ONES; ex_rs2 = 64'd1;
      #1;
      sb.push_back('{pc: 64'h8000_0120, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL blt_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      checks++;
      if (redirect_cnt !== 4'd2) begin
         errors++;
         $display("FAIL blt_cnt: cnt=%0d, expected 2", redirect_cnt);
      end
      clear_redirects();
   endtask

   task automatic test_jumps();
      ex_valid = 1'b1; ex_jump = 1'b1; ex_jalr = 1'b1;
      ex_rs1 = 64'h8000_0101; ex_imm = 64'd2;
      #1;
      checks++;
      if (flush !== 1'b1) begin
         errors++;
         $display("FAIL jalr_flush: flush=%b, expected 1", flush);
      end
`ifdef PC_GEN_MISALIGN_EN
      sb.push_back('{pc: 64'h8000_0120, vld: 1'b1});
`else
      sb.push_back('{pc: 64'h8000_0102, vld: 1'b1});
`endif
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL jalr_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      checks++;
`ifdef PC_GEN_MISALIGN_EN
      if (misalign !== 1'b1 || misalign_addr !== 64'h8000_0102) begin
         errors++;
         $display("FAIL jalr_misalign: misalign=%b addr=%h, expected 1/%h", misalign, misalign_addr, 64'h8000_0102);
      end
`else
      if (misalign !== 1'b0 || misalign_addr !== 64'h0) begin
         errors++;
         $display("FAIL jalr_misalign: misalign=%b addr=%h, expected 0/0", misalign, misalign_addr);
      end
`endif
      checks++;
      if (redirect_cnt !== 4'd3) begin
         errors++;
         $display("FAIL jalr_cnt: cnt=%0d, expected 3", redirect_cnt);
      end
      // JAL to an aligned target
      ex_jalr = 1'b0; ex_pc = 64'h8000_0200; ex_imm = 64'h40; ex_rs1 = 64'h0;
      sb.push_back('{pc: 64'h8000_0240, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL jal_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      checks++;
      if (misalign !== 1'b0 || redirect_cnt !== 4'd4) begin
         errors++;
         $display("FAIL jal_state: misalign=%b cnt=%0d, expected 0/4", misalign, redirect_cnt);
      end
      clear_redirects();
   endtask

   task automatic test_priority();
      trap_valid = 1'b1; trap_vec = 64'h8000_0400;
      mret_valid = 1'b1; mepc = 64'h8000_0800;
      ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 64'h8000_0200; ex_imm = 64'h80;
      #1;
      checks++;
      if (flush !== 1'b1) begin
         errors++;
         $display("FAIL prio_flush: flush=%b, expected 1", flush);
      end
      sb.push_back('{pc: 64'h8000_0400, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL prio_trap: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      trap_valid = 1'b0;
      sb.push_back('{pc: 64'h8000_0800, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL prio_mret: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      mret_valid = 1'b0;
      sb.push_back('{pc: 64'h8000_0280, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL prio_ex: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      checks++;
      if (redirect_cnt !== 4'd7) begin
         errors++;
         $display("FAIL prio_cnt: cnt=%0d, expected 7", redirect_cnt);
      end
      clear_redirects();
   endtask

   task automatic test_hold_freeze();
      if_ready = 1'b0;
      sb.push_back('{pc: 64'h8000_0280, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL hold_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      ena = 1'b0;
      ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 64'h8000_0300; ex_imm = 64'h0;
      trap_valid = 1'b1; trap_vec = 64'h8000_0400;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL freeze_flush: flush=%b, expected 0", flush);
      end
      sb.push_back('{pc: 64'h8000_0280, vld: 1'b0});
      sb.push_back('{pc: 64'h8000_0280, vld: 1'b0});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL freeze_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      clear_redirects();
      ena = 1'b1; if_ready = 1'b1;
      sb.push_back('{pc: 64'h8000_0280, vld: 1'b1});
      sb.push_back('{pc: 64'h8000_0284, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL unfreeze_pc: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      checks++;
      if (redirect_cnt !== 4'd7) begin
         errors++;
         $display("FAIL freeze_cnt: cnt=%0d, expected 7", redirect_cnt);
      end
   endtask

   task automatic test_halt();
      if_ready = 1'b0; halt = 1'b1;
      sb.push_back('{pc: 64'h8000_0284, vld: 1'b0});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL halt_enter: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      halt = 1'b0; if_ready = 1'b1;
      trap_valid = 1'b1; trap_vec = 64'h8000_0400;
      ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 64'h8000_0500; ex_imm = 64'h0;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL halt_flush: flush=%b, expected 0", flush);
      end
      for (int i = 0; i < 3; i++) sb.push_back('{pc: 64'h8000_0284, vld: 1'b0});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL halt_hold: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
      clear_redirects();
      if_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pc !== RST || pc_valid !== 1'b0 || redirect_cnt !== 4'd0) begin
         errors++;
         $display("FAIL halt_reset: pc=%h pc_valid=%b cnt=%0d, expected pc=%h pc_valid=0 cnt=0", pc, pc_valid, redirect_cnt, RST);
      end
      rst_n = 1'b1;
      sb.push_back('{pc: RST, vld: 1'b1});
      while (sb.size() > 0) begin
         step();
         e = sb.pop_front();
         checks++;
         if (pc !== e.pc || pc_valid !== e.vld) begin
            errors++;
            $display("FAIL halt_reboot: pc=%h pc_valid=%b, expected pc=%h pc_valid=%b", pc, pc_valid, e.pc, e.vld);
         end
      end
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] exp_cnt;
      trap_valid = 1'b1; trap_vec = 64'h8000_0400;
      for (int i = 1; i <= 18; i++) begin
         step();
         exp_cnt = (i > 15) ? 4'd15 : 4'(i);
         checks++;
         if (redirect_cnt !== exp_cnt || pc !== 64'h8000_0400) begin
            errors++;
            $display("FAIL sat_%0d: cnt=%0d pc=%h, expected cnt=%0d pc=%h", i, redirect_cnt, pc, exp_cnt, 64'h8000_0400);
         end
      end
      clear_redirects();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_bne();
      test_branch_conditions();
      test_jumps();
      test_priority();
      test_hold_freeze();
      test_halt();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_gen
